// File: rtl/fifo_rd_fwft_stage_pkg.sv
// fifo_rd_fwft_stage_pkg: shared helpers and parameter limits for the FIFO read stage
package tproc_fifo_pkg;
  localparam int RD_LAT_MAX = 2;
  localparam int OUT_DEPTH_MAX = 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_rd_fwft_stage_lat_pipe.sv
// fwft_lat_pipe: per-pop valid shift register tracking the FIFO read latency
module fwft_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o
);
  logic [LAT-1:0] q;
  always_ff @(posedge clk_i)
    q <= clr_i ? '0 : LAT'({q, in_i});
  assign out_o = q[LAT-1];
endmodule

// File: rtl/fifo_rd_fwft_stage.sv
// fifo_rd_fwft_stage: first-word-fall-through prefetch stage hiding BRAM FIFO read latency
module fifo_rd_fwft_stage
  import tproc_fifo_pkg::*;
#(
  parameter int DW = 16,
  parameter int RD_LAT = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            fifo_empty_i,
  input  logic [DW-1:0]                   fifo_dt_i,
  output logic                            fifo_pop_o,
  output logic                            fifo_rd_en_o,
  input  logic                            flush_i,
  output logic                            fifo_flush_o,
  output logic [DW-1:0]                   m_tdata_o,
  output logic                            m_tvalid_o,
  input  logic                            m_tready_i,
  output logic [cnt_w(OUT_DEPTH)-1:0]     occ_o
);
  localparam int CW = cnt_w(OUT_DEPTH);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(OUT_DEPTH - 1);
  logic [DW-1:0] mem [OUT_DEPTH];
  logic [CW-1:0] occ, infl;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic clr, cap, xfer;
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT out of range");
  end
  if (OUT_DEPTH < 2 || OUT_DEPTH > OUT_DEPTH_MAX) begin : g_bad_out_depth
    $error("OUT_DEPTH out of range");
  end
  assign clr = rst_i | flush_i;
  assign xfer = m_tvalid_o & m_tready_i;
  assign fifo_pop_o = !clr && !fifo_empty_i && (({1'b0, occ} + {1'b0, infl}) < {1'b0, FULL});
  assign fifo_rd_en_o = !rst_i;
  assign m_tvalid_o = occ != '0;
  assign m_tdata_o = mem[rd_ptr];
  assign occ_o = occ;
  fwft_lat_pipe #(.LAT(RD_LAT)) u_lat (
    .clk_i(clk_i),
    .clr_i(clr),
    .in_i (fifo_pop_o),
    .out_o(cap)
  );
  always_ff @(posedge clk_i) begin
    fifo_flush_o <= !rst_i && flush_i;
    if (clr) begin
      occ    <= '0;
      infl   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      occ  <= occ + CW'(cap) - CW'(xfer);
      infl <= infl + CW'(fifo_pop_o) - CW'(cap);
      if (cap) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (xfer) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else if (cap && !flush_i) begin
      mem[wr_ptr] <= fifo_dt_i;
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (clr) !(cap && !xfer && occ == FULL));
endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// tb_fifo_rd_fwft_stage: queue-model bench for three latency/depth configurations
module tb_fifo_rd_fwft_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, rdy, hold;
  logic emp [3];
  logic [15:0] dt [3];
  logic pop [3], rde [3], fl [3], tv [3];
  logic [15:0] td [3];
  logic [1:0] occ [3];
  logic [15:0] src [3][$];
  logic [15:0] bq [3][$];
  logic [15:0] pw [3][$];
  logic [15:0] lg [3][$];
  int pt [3][$];
  logic [15:0] nd [3], d0 [3], d1 [3], sd [3];
  logic efl [3];
  int fv [3], pc [3], sp [3], sv [3], so [3], sf [3];
  int t, tr, n_chk, n_fail;

  fifo_rd_fwft_stage #(.DW(16), .RD_LAT(1), .OUT_DEPTH(2)) u0 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(emp[0]), .fifo_dt_i(dt[0]), .fifo_pop_o(pop[0]),
    .fifo_rd_en_o(rde[0]), .flush_i(flush), .fifo_flush_o(fl[0]), .m_tdata_o(td[0]),
    .m_tvalid_o(tv[0]), .m_tready_i(rdy), .occ_o(occ[0])
  );
  fifo_rd_fwft_stage #(.DW(16), .RD_LAT(2), .OUT_DEPTH(2)) u1 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(emp[1]), .fifo_dt_i(dt[1]), .fifo_pop_o(pop[1]),
    .fifo_rd_en_o(rde[1]), .flush_i(flush), .fifo_flush_o(fl[1]), .m_tdata_o(td[1]),
    .m_tvalid_o(tv[1]), .m_tready_i(rdy), .occ_o(occ[1])
  );
  fifo_rd_fwft_stage #(.DW(16), .RD_LAT(2), .OUT_DEPTH(3)) u2 (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(emp[2]), .fifo_dt_i(dt[2]), .fifo_pop_o(pop[2]),
    .fifo_rd_en_o(rde[2]), .flush_i(flush), .fifo_flush_o(fl[2]), .m_tdata_o(td[2]),
    .m_tvalid_o(tv[2]), .m_tready_i(rdy), .occ_o(occ[2])
  );

  function automatic int lat(input int k);
    return k == 0 ? 1 : 2;
  endfunction
  function automatic int dep(input int k);
    return k == 2 ? 3 : 2;
  endfunction

  task automatic chk(input string nm, input int k, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s u%0d t=%0d got %0h want %0h", nm, k, t, a, e);
    end
  endtask

  task automatic fill(input int base, input int n);
    for (int k = 0; k < 3; k++) begin
      src[k].delete();
      for (int i = 0; i < n; i++) src[k].push_back(16'(base + i));
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) lg[k].delete();
  endtask

  task automatic cyc();
    for (int k = 0; k < 3; k++) emp[k] = (src[k].size() == 0) || hold;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bit ev, ep;
      ev = bq[k].size() != 0;
      ep = !rst && !flush && !emp[k] && (bq[k].size() + pw[k].size() < dep(k));
      chk("pop", k, int'(pop[k]), int'(ep));
      chk("tvalid", k, int'(tv[k]), int'(ev));
      if (ev) chk("tdata", k, int'(td[k]), int'(bq[k][0]));
      chk("occ", k, int'(occ[k]), bq[k].size());
      chk("occ_max", k, int'(occ[k]) <= dep(k) ? 1 : 0, 1);
      chk("flush_o", k, int'(fl[k]), int'(efl[k]));
      chk("rd_en", k, int'(rde[k]), int'(!rst));
      sp[k] = int'(pop[k]);
      sv[k] = int'(tv[k]);
      so[k] = int'(occ[k]);
      sf[k] = int'(fl[k]);
      sd[k] = td[k];
      if (tv[k] && rdy) lg[k].push_back(td[k]);
      if (pop[k]) pc[k]++;
      if (tv[k] && fv[k] < 0) fv[k] = t;
      nd[k] = 16'hDEAD;
      if (rst || flush) begin
        bq[k].delete();
        pw[k].delete();
        pt[k].delete();
      end else begin
        if (ev && rdy) void'(bq[k].pop_front());
        if (ep) begin
          nd[k] = src[k].pop_front();
          pw[k].push_back(nd[k]);
          pt[k].push_back(t + lat(k) + 1);
        end
        while (pt[k].size() != 0 && pt[k][0] == t + 1) begin
          bq[k].push_back(pw[k].pop_front());
          void'(pt[k].pop_front());
        end
      end
      efl[k] = flush && !rst;
    end
    @(posedge clk);
    #1;
    t++;
    for (int k = 0; k < 3; k++) begin
      d1[k] = d0[k];
      d0[k] = nd[k];
      dt[k] = lat(k) == 1 ? d0[k] : d1[k];
    end
  endtask

  task automatic check_log(input string nm, input int n, input int base);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_count"}, k, lg[k].size(), n);
      for (int i = 0; i < n; i++)
        if (i < lg[k].size()) chk({nm, "_order"}, k, int'(lg[k][i]), base + i);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; t = 0;
    rst = 1'b1; flush = 1'b0; rdy = 1'b1; hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dt[k] = '0; d0[k] = '0; d1[k] = '0; efl[k] = 1'b0; fv[k] = -1; pc[k] = 0; emp[k] = 1'b1;
    end
    fill(1, 8);
    repeat (3) begin
      cyc();
      chk("rst_pop", 0, sp[0], 0);
      chk("rst_valid", 0, sv[0], 0);
      chk("rst_tdata", 0, int'(sd[0]), 0);
      chk("rst_occ", 0, so[0], 0);
    end
    rst = 1'b0;
    tr = t;
    cyc();
    chk("first_pop", 0, sp[0], 1);
    repeat (30) cyc();
    chk("latency", 0, fv[0] - tr, 2);
    chk("latency", 1, fv[1] - tr, 3);
    chk("latency", 2, fv[2] - tr, 3);
    check_log("stream", 8, 1);
    clear_logs();
    fill(1, 8);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) pc[k] = 0;
    repeat (6) cyc();
    chk("bp_pops", 0, pc[0], 2);
    chk("bp_pops", 1, pc[1], 2);
    chk("bp_pops", 2, pc[2], 3);
    chk("bp_occ", 0, so[0], 2);
    chk("bp_valid", 0, sv[0], 1);
    chk("bp_tdata", 0, int'(sd[0]), 16'h0001);
    chk("bp_pop_idle", 0, sp[0], 0);
    rdy = 1'b1;
    repeat (30) cyc();
    check_log("bp", 8, 1);
    clear_logs();
    hold = 1'b1;
    fill(16'h11, 8);
    cyc();
    hold = 1'b0;
    cyc();
    chk("fl_pop_n", 1, sp[1], 1);
    flush = 1'b1;
    cyc();
    chk("fl_pop_blocked", 1, sp[1], 0);
    chk("fl_o_n1", 1, sf[1], 0);
    flush = 1'b0;
    fill(0, 0);
    cyc();
    chk("fl_o_n2", 1, sf[1], 1);
    chk("fl_valid_n2", 1, sv[1], 0);
    chk("fl_occ_n2", 1, so[1], 0);
    cyc();
    chk("fl_o_n3", 1, sf[1], 0);
    repeat (5) cyc();
    for (int k = 0; k < 3; k++) chk("fl_dropped", k, lg[k].size(), 0);
    clear_logs();
    fill(16'h100, 20);
    repeat (60) begin
      hold = ~hold;
      rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    hold = 1'b0;
    rdy = 1'b1;
    repeat (30) cyc();
    check_log("toggle", 20, 16'h100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
